// File: rtl/d_latch_seq_pkg.sv
// Shared definitions for the gated D-latch write sequencer.
//
// Contents:
//   state_t  - FSM state encoding (3-bit)
//   DEF_*    - default word width and timing windows
//   max3     - helper to size the phase counter from the three windows
package d_latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    CHECK  = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_EN_CYC    = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the setup / enable / hold windows.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   srst       - synchronous active-high reset, clears the count
//   load       - load load_value (has priority over decrement)
//   load_value - value to load
//   decrement  - count down by one; saturates at zero
//   zero       - count is zero
module phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          decrement,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (decrement && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/d_latch_write_sequencer.sv
// Write sequencer for a bank of gated D latches.
//
// Accepts a word over a valid/ready handshake, presents it on D, raises E
// for EN_CYC cycles framed by SETUP_CYC cycles before and HOLD_CYC cycles
// after, then reads Q back and pulses DONE (and ERR on a mismatch).
//
// Ports:
//   CLK      - clock
//   RST      - synchronous active-high reset
//   IN_DATA  - word to write
//   IN_VALID - IN_DATA valid
//   IN_READY - ready to accept (combinational: IDLE and not in reset)
//   D        - registered data to the latch bank
//   E        - registered enable to the latch bank
//   Q        - latch bank read-back
//   BUSY     - write in progress (cycle after acceptance through CHECK)
//   DONE     - one-cycle write-complete pulse
//   ERR      - one-cycle pulse with DONE when read-back differs from D
module d_latch_write_sequencer
  import d_latch_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] D,
  output logic             E,
  input  logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int CW = $clog2(max3(SETUP_CYC, EN_CYC, HOLD_CYC) + 1);

  // Counter reload values: a window of N cycles counts N-1 .. 0.
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] d_reg;
  logic             e_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic             accept;
  logic             timer_load;
  logic [CW-1:0]    timer_load_value;
  logic             timer_dec;
  logic             timer_zero;
  logic [WIDTH-1:0] bit_diff;
  logic             mismatch;

  assign IN_READY = (state_reg == IDLE) && !RST;
  assign accept   = IN_VALID && IN_READY;

  phase_timer #(
    .CW(CW)
  ) u_phase_timer (
    .clk       (CLK),
    .srst      (RST),
    .load      (timer_load),
    .load_value(timer_load_value),
    .decrement (timer_dec),
    .zero      (timer_zero)
  );

  // Per-bit read-back compare against the word currently driven on D.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cmp
      assign bit_diff[gi] = Q[gi] ^ d_reg[gi];
    end
  endgenerate
  assign mismatch = |bit_diff;

  always_comb begin
    state_next       = state_reg;
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_dec        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next       = SETUP;
          timer_load       = 1'b1;
          timer_load_value = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (timer_zero) begin
          state_next       = ENABLE;
          timer_load       = 1'b1;
          timer_load_value = EN_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ENABLE: begin
        if (timer_zero) begin
          state_next       = HOLD;
          timer_load       = 1'b1;
          timer_load_value = HOLD_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      HOLD: begin
        if (timer_zero) begin
          state_next = CHECK;
        end else begin
          timer_dec = 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // E is decoded from the next state into its own flop so the latch enable
  // is a clean flop output, high exactly while the FSM sits in ENABLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      d_reg     <= '0;
      e_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        d_reg <= IN_DATA;
      end
      e_reg    <= (state_next == ENABLE);
      busy_reg <= (state_next != IDLE);
      // Q is sampled in CHECK: E has been low for at least one full cycle.
      done_reg <= (state_reg == CHECK);
      err_reg  <= (state_reg == CHECK) && mismatch;
    end
  end

  assign D    = d_reg;
  assign E    = e_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign ERR  = err_reg;

endmodule

// File: tb/tb_d_latch_write_sequencer.sv
module tb_d_latch_write_sequencer;

  localparam int S  = 1;
  localparam int EN = 2;
  localparam int H  = 1;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;

  // Default-timing instance
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d;
  logic       e;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] latch_q;
  logic       stuck;

  // SETUP=3, EN=1, HOLD=2 instance
  logic [3:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic [3:0] d2;
  logic       e2;
  logic [3:0] q2;
  logic       busy2;
  logic       done2;
  logic       err2;
  logic [3:0] latch_q2;

  exp_t sb_q[$];
  exp_t sb2_q[$];
  exp_t sb_item;
  exp_t sb2_item;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  d_latch_write_sequencer dut (
    .CLK     (clk),
    .RST     (rst),
    .IN_DATA (in_data),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .D       (d),
    .E       (e),
    .Q       (q),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err)
  );

  d_latch_write_sequencer #(
    .WIDTH    (4),
    .SETUP_CYC(3),
    .EN_CYC   (1),
    .HOLD_CYC (2)
  ) dut2 (
    .CLK     (clk),
    .RST     (rst),
    .IN_DATA (in_data2),
    .IN_VALID(in_valid2),
    .IN_READY(in_ready2),
    .D       (d2),
    .E       (e2),
    .Q       (q2),
    .BUSY    (busy2),
    .DONE    (done2),
    .ERR     (err2)
  );

  // Gated D latch models; 'stuck' forces the first bank's read-back to 0.
  always @(e or d) if (e) latch_q = d;
  always @(e2 or d2) if (e2) latch_q2 = d2;
  assign q  = stuck ? 4'h0 : latch_q;
  assign q2 = latch_q2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: completions are checked against queued expectations.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(done), 32'(0));
      end else begin
        sb_item = sb_q.pop_front();
        chk("sb_err", 32'(err), 32'(sb_item.err));
        chk("sb_d", 32'(d), 32'(sb_item.data));
        $display("done: d=%h err=%b (exp data=%h err=%b)", d, err, sb_item.data, sb_item.err);
      end
    end
    if (!rst && done2) begin
      if (sb2_q.size() == 0) begin
        chk("sb2_unexpected_done", 32'(done2), 32'(0));
      end else begin
        sb2_item = sb2_q.pop_front();
        chk("sb2_err", 32'(err2), 32'(sb2_item.err));
        chk("sb2_d", 32'(d2), 32'(sb2_item.data));
        $display("done2: d=%h err=%b (exp data=%h err=%b)", d2, err2, sb2_item.data, sb2_item.err);
      end
    end
  end

  // Present a word in the current cycle (cycle 0) and check cycles 1..6.
  // During cycles 1..5 the inputs show busy_data/busy_valid, which must be
  // ignored.
  task automatic do_write(input logic [3:0] data, input logic [3:0] busy_data,
                          input logic busy_valid, input logic exp_err);
    in_data  = data;
    in_valid = 1'b1;
    #1;
    chk("ready_c0", 32'(in_ready), 32'(1));
    sb_q.push_back(exp_t'{data: data, err: exp_err});
    $display("write: data=%h accepted, expect err=%b", data, exp_err);
    for (int c = 1; c <= S + EN + H + 2; c++) begin
      tick();
      if (c <= S + EN + H + 1) begin
        in_data  = busy_data;
        in_valid = busy_valid;
      end
      chk($sformatf("e_c%0d", c), 32'(e), 32'((c >= S + 1) && (c <= S + EN)));
      chk($sformatf("d_c%0d", c), 32'(d), 32'(data));
      chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= S + EN + H + 1));
      chk($sformatf("done_c%0d", c), 32'(done), 32'(c == S + EN + H + 2));
      chk($sformatf("err_c%0d", c), 32'(err), 32'(exp_err && (c == S + EN + H + 2)));
      chk($sformatf("ready_c%0d", c), 32'(in_ready), 32'(c == S + EN + H + 2));
    end
  endtask

  initial begin
    rst       = 1'b1;
    stuck     = 1'b0;
    in_data   = 4'h0;
    in_valid  = 1'b0;
    in_data2  = 4'h0;
    in_valid2 = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", 32'(in_ready), 32'(0));
    chk("rst_ready2", 32'(in_ready2), 32'(0));
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_e", 32'(e), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'(1));

    // 1: single write
    do_write(4'hA, 4'h0, 1'b0, 1'b0);

    // 2: IN_VALID held high, back-to-back
    do_write(4'h5, 4'h3, 1'b1, 1'b0);
    do_write(4'h3, 4'h0, 1'b0, 1'b0);

    // 3: word offered while busy is not taken until IDLE
    do_write(4'h1, 4'h9, 1'b1, 1'b0);
    do_write(4'h9, 4'h0, 1'b0, 1'b0);

    // 4: stuck read-back -> ERR with DONE, both drop next cycle
    stuck = 1'b1;
    do_write(4'hF, 4'h0, 1'b0, 1'b1);
    tick();
    chk("stuck_done_c7", 32'(done), 32'(0));
    chk("stuck_err_c7", 32'(err), 32'(0));
    stuck = 1'b0;

    // 5: reset in ENABLE aborts the write
    in_data  = 4'hC;
    in_valid = 1'b1;
    #1;
    chk("abort_ready_c0", 32'(in_ready), 32'(1));
    $display("write: data=%h accepted, reset expected mid-write", in_data);
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort_e_c2", 32'(e), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_e_c3", 32'(e), 32'(0));
    chk("abort_d_c3", 32'(d), 32'(0));
    chk("abort_busy_c3", 32'(busy), 32'(0));
    chk("abort_ready_c3", 32'(in_ready), 32'(1));
    for (int c = 4; c <= 10; c++) begin
      tick();
      chk($sformatf("abort_done_c%0d", c), 32'(done), 32'(0));
    end

    // 6: SETUP=3, EN=1, HOLD=2 instance
    in_data2  = 4'h6;
    in_valid2 = 1'b1;
    #1;
    chk("t6_ready_c0", 32'(in_ready2), 32'(1));
    sb2_q.push_back(exp_t'{data: 4'h6, err: 1'b0});
    $display("write2: data=%h accepted, expect err=0", in_data2);
    for (int c = 1; c <= 8; c++) begin
      tick();
      in_valid2 = 1'b0;
      chk($sformatf("t6_e_c%0d", c), 32'(e2), 32'(c == 4));
      chk($sformatf("t6_d_c%0d", c), 32'(d2), 32'(4'h6));
      chk($sformatf("t6_busy_c%0d", c), 32'(busy2), 32'(c <= 7));
      chk($sformatf("t6_done_c%0d", c), 32'(done2), 32'(c == 8));
      chk($sformatf("t6_err_c%0d", c), 32'(err2), 32'(0));
      chk($sformatf("t6_ready_c%0d", c), 32'(in_ready2), 32'(c == 8));
    end
    tick();
    chk("t6_done_c9", 32'(done2), 32'(0));

    // Every expected completion must have been observed
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    chk("sb2_empty", 32'(sb2_q.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
